// File: rtl/vc_sram_rd_arbiter_if.sv
// vc_sram_rd_arbiter_if: client-side read request/response and write bus of the SRAM read arbiter
interface vc_sram_rd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req_val;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_rdy;
  logic [NUM_REQ-1:0]            resp_val;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          wr_val;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  modport master (output req_val, req_addr, wr_val, wr_addr, wr_data, input req_rdy, resp_val, resp_data);
  modport slave  (input req_val, req_addr, wr_val, wr_addr, wr_data, output req_rdy, resp_val, resp_data);
endinterface

// File: rtl/vc_sram_rd_arbiter.sv
// vc_sram_rd_arbiter: round-robin sharing of a 1R1W SRAM read port with same-cycle write-to-read bypass
module vc_sram_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 12,
  parameter int NUM_WORDS = 16,
  localparam int ADDR_WIDTH = $clog2(NUM_WORDS),
  localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  vc_sram_rd_arbiter_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] sram_rdaddress,
  output logic [ADDR_WIDTH-1:0] sram_wraddress,
  output logic [DATA_WIDTH-1:0] sram_data_in,
  output logic                  sram_wren,
  input  logic [DATA_WIDTH-1:0] sram_data_out
);
  logic [IDX_WIDTH-1:0]  r_ptr;
  logic [NUM_REQ-1:0]    r_resp_val;
  logic                  r_byp_hit;
  logic [DATA_WIDTH-1:0] r_byp_data;
  logic                  w_any;
  logic [IDX_WIDTH-1:0]  w_idx, w_c, w_nxt;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [ADDR_WIDTH-1:0] w_addr;
  // scan from the farthest offset down so the first requester after r_ptr wins
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_c = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_c = IDX_WIDTH'((32'(r_ptr) + k) % NUM_REQ);
      if (bus.req_val[w_c]) begin
        w_any = !rst;
        w_idx = w_c;
      end
    end
  end
  assign w_gnt = w_any ? NUM_REQ'(1) << w_idx : '0;
  assign w_nxt = (w_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_addr = bus.req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.req_rdy = w_gnt;
  assign bus.resp_val = r_resp_val;
  assign bus.resp_data = r_byp_hit ? r_byp_data : sram_data_out;
  assign sram_rdaddress = w_any ? w_addr : '0;
  assign sram_wren = bus.wr_val;
  assign sram_wraddress = bus.wr_addr;
  assign sram_data_in = bus.wr_data;
  // the SRAM returns old data on a same-address read/write, so capture the write for that case
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_resp_val <= '0;
      r_byp_hit <= 1'b0;
      r_byp_data <= '0;
    end else begin
      if (w_any) r_ptr <= w_nxt;
      r_resp_val <= w_gnt;
      r_byp_hit <= w_any && bus.wr_val && (bus.wr_addr == w_addr);
      r_byp_data <= bus.wr_data;
    end
  end
endmodule
